// File: rtl/particle_telemetry.sv
// Decimating particle-stream tap: samples and per-step markers are queued in a
// small record FIFO and streamed as framed bytes over a UART 8N1 transmitter.
module particle_telemetry #(
  parameter int PSIZE        = 50,
  parameter int CLKS_PER_BIT = 868,
  parameter int DECIM        = 256,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             valid_in,
  input  logic             tlast_in,
  input  logic [PSIZE-1:0] particle_in,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      step_count,
  output logic [15:0]      drop_count
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef struct packed {
    logic        kind;     // 1 = step marker, 0 = particle sample
    logic [55:0] payload;
  } rec_t;

  typedef enum logic [1:0] {F_IDLE, F_POP, F_LOAD, F_SEND} fstate_t;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

  // ---------------- capture / decimation ----------------
  logic [15:0]   step_q, step_d, drop_q, drop_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          wr_en;
  rec_t          wr_rec;

  always_comb begin
    wr_en  = 1'b0;
    wr_rec = '0;
    step_d = step_q;
    dcnt_d = dcnt_q;
    if (valid_in) begin
      if (tlast_in) begin
        wr_en  = 1'b1;
        wr_rec = {1'b1, 40'd0, step_q};
        step_d = step_q + 16'd1;
        dcnt_d = '0;
      end else if (enable) begin
        wr_en          = (dcnt_q == '0);
        wr_rec.payload = 56'(particle_in);
        dcnt_d         = (dcnt_q == DW'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;
      end
    end
  end

  // ---------------- record FIFO ----------------
  rec_t          mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fcnt;
  logic          full, empty, push, pop;
  fstate_t       fstate_q, fstate_d;

  assign fcnt  = wr_ptr_q - rd_ptr_q;
  assign full  = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (fcnt == '0);
  // Fullness is judged on the registered count, so a same-cycle pop never rescues a write.
  assign push  = wr_en & ~full;
  assign pop   = (fstate_q == F_POP);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drop_d   = (wr_en && full && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
  end

  // ---------------- frame FSM ----------------
  logic [63:0] sh_q, sh_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        u_start, u_done;
  rec_t        head;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    fstate_d = fstate_q;
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    u_start  = 1'b0;
    case (fstate_q)
      F_IDLE: if (!empty) fstate_d = F_POP;
      F_POP: begin
        if (head.kind) begin
          sh_d   = {40'd0, head.payload[15:0], 8'h5A};
          bcnt_d = 4'd3;
        end else begin
          sh_d   = {head.payload, 8'hA5};
          bcnt_d = 4'd8;
        end
        fstate_d = F_LOAD;
      end
      F_LOAD: begin
        u_start  = 1'b1;
        sh_d     = sh_q >> 8;
        bcnt_d   = bcnt_q - 4'd1;
        fstate_d = F_SEND;
      end
      F_SEND: if (u_done) begin
        if (bcnt_q != 4'd0) begin
          // Restart the UART on the stop bit's final cycle for gapless bytes.
          u_start = 1'b1;
          sh_d    = sh_q >> 8;
          bcnt_d  = bcnt_q - 4'd1;
        end else begin
          fstate_d = empty ? F_IDLE : F_POP;
        end
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  // ---------------- UART 8N1 transmitter ----------------
  ustate_t       ustate_q, ustate_d;
  logic [CW-1:0] ucnt_q, ucnt_d;
  logic [2:0]    ubit_q, ubit_d;
  logic [7:0]    ush_q, ush_d;
  logic          tx_q, tx_d, bit_end;

  assign bit_end = (ucnt_q == CW'(CLKS_PER_BIT - 1));
  assign u_done  = (ustate_q == U_STOP) && bit_end;

  always_comb begin
    ustate_d = ustate_q;
    ucnt_d   = bit_end ? '0 : ucnt_q + 1'b1;
    ubit_d   = ubit_q;
    ush_d    = ush_q;
    tx_d     = tx_q;
    case (ustate_q)
      U_IDLE: begin
        ucnt_d = '0;
        if (u_start) begin
          ustate_d = U_START;
          ush_d    = sh_q[7:0];
          tx_d     = 1'b0;
        end
      end
      U_START: if (bit_end) begin
        ustate_d = U_DATA;
        ubit_d   = 3'd0;
        tx_d     = ush_q[0];
      end
      U_DATA: if (bit_end) begin
        if (ubit_q == 3'd7) begin
          ustate_d = U_STOP;
          tx_d     = 1'b1;
        end else begin
          ubit_d = ubit_q + 3'd1;
          ush_d  = ush_q >> 1;
          tx_d   = ush_q[1];
        end
      end
      U_STOP: if (bit_end) begin
        if (u_start) begin
          ustate_d = U_START;
          ush_d    = sh_q[7:0];
          tx_d     = 1'b0;
        end else begin
          ustate_d = U_IDLE;
        end
      end
      default: ustate_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      drop_q   <= '0;
      dcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fstate_q <= F_IDLE;
      sh_q     <= '0;
      bcnt_q   <= '0;
      ustate_q <= U_IDLE;
      ucnt_q   <= '0;
      ubit_q   <= '0;
      ush_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      step_q   <= step_d;
      drop_q   <= drop_d;
      dcnt_q   <= dcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fstate_q <= fstate_d;
      sh_q     <= sh_d;
      bcnt_q   <= bcnt_d;
      ustate_q <= ustate_d;
      ucnt_q   <= ucnt_d;
      ubit_q   <= ubit_d;
      ush_q    <= ush_d;
      tx_q     <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = ~empty | (fstate_q != F_IDLE);
  assign step_count = step_q;
  assign drop_count = drop_q;
endmodule
